// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin / fixed-priority stream arbiter.
package arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccept = 2'd1,
        StEmit   = 2'd2
    } state_t;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;

    // Ceiling log2, never below 1 so that single-value fields still get a bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner search over a request vector.
// Round-robin searches upward from i_start+1 with wrap; fixed priority takes the lowest index.
module rr_pick
    import arbiter_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TAG_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [TAG_W-1:0]    i_start,
    input  logic                i_mode,   // 1 = fixed priority, 0 = round-robin
    output logic [TAG_W-1:0]    o_win,
    output logic                o_any
);

    logic [TAG_W-1:0] w_idx;
    logic [TAG_W-1:0] w_win;
    logic             w_found;

    // Walk the candidates in priority order and keep the first one that requests.
    always_comb begin
        w_idx   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (i_mode) begin
                w_idx = TAG_W'(k);
            end else begin
                w_idx = TAG_W'((32'(i_start) + k + 1) % CHANNELS);
            end
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign o_win = w_win;
    assign o_any = |i_req;

endmodule

// File: rtl/arbiter_rr.sv
// N-channel stb/ack stream arbiter with optional burst lock and source tagging.
module arbiter_rr
    import arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned BURST    = 1,
    parameter int unsigned TAG_W    = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] input_data,
    input  logic [CHANNELS-1:0]       input_stb,
    output logic [CHANNELS-1:0]       input_ack,
    output logic [WIDTH-1:0]          output_z,
    output logic [TAG_W-1:0]          output_z_tag,
    output logic                      output_z_stb,
    input  logic                      output_z_ack
);

    localparam int unsigned CntW = clog2(BURST);

    state_t                r_state;
    state_t                w_state_next;
    logic [TAG_W-1:0]      r_sel;
    logic [TAG_W-1:0]      w_sel_next;
    logic [CHANNELS-1:0]   r_ack;
    logic [CHANNELS-1:0]   w_ack_next;
    logic [WIDTH-1:0]      r_z;
    logic [WIDTH-1:0]      w_z_next;
    logic [TAG_W-1:0]      r_tag;
    logic [TAG_W-1:0]      w_tag_next;
    logic                  r_stb;
    logic                  w_stb_next;
    logic [CntW-1:0]       r_burst_cnt;
    logic [CntW-1:0]       w_burst_next;

    logic [WIDTH-1:0]      w_words [CHANNELS];
    logic [TAG_W-1:0]      w_pick;
    logic                  w_any;
    logic                  w_lock;
    logic [TAG_W-1:0]      w_grant;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_words
        assign w_words[g] = input_data[g*WIDTH +: WIDTH];
    end

    rr_pick #(
        .CHANNELS (CHANNELS),
        .TAG_W    (TAG_W)
    ) u_pick (
        .i_req   (input_stb),
        .i_start (r_sel),
        .i_mode  (MODE == MODE_FIXED),
        .o_win   (w_pick),
        .o_any   (w_any)
    );

    // A partially used burst keeps the grant while the same channel still requests.
    assign w_lock  = (r_burst_cnt != '0) && input_stb[r_sel];
    assign w_grant = w_lock ? r_sel : w_pick;

    // Next-state and next-output logic for the IDLE/ACCEPT/EMIT handshake.
    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_ack_next   = r_ack;
        w_z_next     = r_z;
        w_tag_next   = r_tag;
        w_stb_next   = r_stb;
        w_burst_next = r_burst_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_any) begin
                    if (!w_lock) begin
                        w_burst_next = '0;
                    end
                    w_sel_next   = w_grant;
                    w_ack_next   = CHANNELS'(1) << w_grant;
                    w_state_next = StAccept;
                end
            end
            StAccept: begin
                // Ack is held until the selected producer completes the transfer.
                if (input_stb[r_sel]) begin
                    w_z_next     = w_words[r_sel];
                    w_tag_next   = r_sel;
                    w_ack_next   = '0;
                    w_stb_next   = 1'b1;
                    w_state_next = StEmit;
                end
            end
            StEmit: begin
                if (output_z_ack) begin
                    w_stb_next   = 1'b0;
                    w_burst_next = (r_burst_cnt == CntW'(BURST - 1)) ? '0 : r_burst_cnt + 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_sel       <= TAG_W'(CHANNELS - 1);
            r_ack       <= '0;
            r_z         <= '0;
            r_tag       <= '0;
            r_stb       <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_sel       <= w_sel_next;
            r_ack       <= w_ack_next;
            r_z         <= w_z_next;
            r_tag       <= w_tag_next;
            r_stb       <= w_stb_next;
            r_burst_cnt <= w_burst_next;
        end
    end

    assign input_ack    = r_ack;
    assign output_z     = r_z;
    assign output_z_tag = r_tag;
    assign output_z_stb = r_stb;

endmodule

// File: tb/tb_arbiter_rr.sv
// Scoreboard bench for arbiter_rr: four instances cover round-robin, fixed priority,
// burst lock and a three-channel wrap-around case.
module tb_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Round-robin, 4 channels, no burst.
    logic [63:0] rr_data;
    logic [3:0]  rr_stb, rr_ack;
    logic [15:0] rr_z;
    logic [1:0]  rr_tag;
    logic        rr_zstb, rr_zack;
    // Fixed priority, 4 channels.
    logic [63:0] fx_data;
    logic [3:0]  fx_stb, fx_ack;
    logic [15:0] fx_z;
    logic [1:0]  fx_tag;
    logic        fx_zstb, fx_zack;
    // Round-robin with burst lock of 3.
    logic [63:0] bu_data;
    logic [3:0]  bu_stb, bu_ack;
    logic [15:0] bu_z;
    logic [1:0]  bu_tag;
    logic        bu_zstb, bu_zack;
    // Round-robin, 3 channels.
    logic [47:0] w3_data;
    logic [2:0]  w3_stb, w3_ack;
    logic [15:0] w3_z;
    logic [1:0]  w3_tag;
    logic        w3_zstb, w3_zack;

    arbiter_rr #(.WIDTH(16), .CHANNELS(4), .MODE(0), .BURST(1)) u_rr (
        .clk(clk), .rst(rst), .input_data(rr_data), .input_stb(rr_stb), .input_ack(rr_ack),
        .output_z(rr_z), .output_z_tag(rr_tag), .output_z_stb(rr_zstb), .output_z_ack(rr_zack)
    );
    arbiter_rr #(.WIDTH(16), .CHANNELS(4), .MODE(1), .BURST(1)) u_fx (
        .clk(clk), .rst(rst), .input_data(fx_data), .input_stb(fx_stb), .input_ack(fx_ack),
        .output_z(fx_z), .output_z_tag(fx_tag), .output_z_stb(fx_zstb), .output_z_ack(fx_zack)
    );
    arbiter_rr #(.WIDTH(16), .CHANNELS(4), .MODE(0), .BURST(3)) u_bu (
        .clk(clk), .rst(rst), .input_data(bu_data), .input_stb(bu_stb), .input_ack(bu_ack),
        .output_z(bu_z), .output_z_tag(bu_tag), .output_z_stb(bu_zstb), .output_z_ack(bu_zack)
    );
    arbiter_rr #(.WIDTH(16), .CHANNELS(3), .MODE(0), .BURST(1)) u_w3 (
        .clk(clk), .rst(rst), .input_data(w3_data), .input_stb(w3_stb), .input_ack(w3_ack),
        .output_z(w3_z), .output_z_tag(w3_tag), .output_z_stb(w3_zstb), .output_z_ack(w3_zack)
    );

    // Expected words as {tag, data}.
    logic [17:0] q_rr[$];
    logic [17:0] q_fx[$];
    logic [17:0] q_bu[$];
    logic [17:0] q_w3[$];
    int          n_rr = 0, n_fx = 0, n_bu = 0, n_w3 = 0;
    int          t_rr[$];
    bit          gap_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic score(input string name, input logic [17:0] got, input logic [17:0] exp,
                         input bit have);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s unexpected word: got tag=%0d data=%h, required none",
                     name, got[17:16], got[15:0]);
        end else if (got !== exp) begin
            errors++;
            $display("FAIL %s word: got tag=%0d data=%h, required tag=%0d data=%h",
                     name, got[17:16], got[15:0], exp[17:16], exp[15:0]);
        end
    endtask

    // Monitors: every output handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && rr_zstb && rr_zack) begin
            if (q_rr.size() == 0) score("rr", {rr_tag, rr_z}, 18'h0, 1'b0);
            else score("rr", {rr_tag, rr_z}, q_rr.pop_front(), 1'b1);
            if (gap_en) t_rr.push_back(cyc);
            n_rr <= n_rr + 1;
        end
    end
    always @(negedge clk) begin
        if (!rst && fx_zstb && fx_zack) begin
            if (q_fx.size() == 0) score("fx", {fx_tag, fx_z}, 18'h0, 1'b0);
            else score("fx", {fx_tag, fx_z}, q_fx.pop_front(), 1'b1);
            n_fx <= n_fx + 1;
        end
    end
    always @(negedge clk) begin
        if (!rst && bu_zstb && bu_zack) begin
            if (q_bu.size() == 0) score("bu", {bu_tag, bu_z}, 18'h0, 1'b0);
            else score("bu", {bu_tag, bu_z}, q_bu.pop_front(), 1'b1);
            n_bu <= n_bu + 1;
        end
    end
    always @(negedge clk) begin
        if (!rst && w3_zstb && w3_zack) begin
            if (q_w3.size() == 0) score("w3", {w3_tag, w3_z}, 18'h0, 1'b0);
            else score("w3", {w3_tag, w3_z}, q_w3.pop_front(), 1'b1);
            n_w3 <= n_w3 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int words(input int id);
        case (id)
            0:       return n_rr;
            1:       return n_fx;
            2:       return n_bu;
            default: return n_w3;
        endcase
    endfunction

    task automatic wait_words(input int id, input int target);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (words(id) >= target) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_words id=%0d: got %0d words, required %0d", id, words(id), target);
        end
    endtask

    // Bounded wait for rr output valid (id 0) or any w3 ack (id 3).
    task automatic wait_sig(input int id);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (id == 0) seen = rr_zstb;
            else seen = |w3_ack;
            if (!seen) tick();
        end
        check($sformatf("wait_sig id=%0d", id), 32'(seen), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        rr_data = '0; rr_stb = '0; rr_zack = 1'b1;
        fx_data = '0; fx_stb = '0; fx_zack = 1'b1;
        bu_data = '0; bu_stb = '0; bu_zack = 1'b1;
        w3_data = '0; w3_stb = '0; w3_zack = 1'b1;
        repeat (3) tick();
        check("reset rr outputs", {rr_zstb, rr_ack, rr_tag, rr_z}, 32'h0);
        check("reset w3 outputs", {w3_zstb, w3_ack, w3_tag, w3_z}, 32'h0);
        rst = 1'b0;

        // Fairness: all four request, consumer always ready.
        rr_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        q_rr.push_back({2'd0, 16'h1000});
        q_rr.push_back({2'd1, 16'h1001});
        q_rr.push_back({2'd2, 16'h1002});
        q_rr.push_back({2'd3, 16'h1003});
        q_rr.push_back({2'd0, 16'h1000});
        gap_en = 1'b1;
        rr_stb = 4'hF;
        wait_words(0, 5);
        rr_stb = '0;
        gap_en = 1'b0;
        check("rr gap samples", t_rr.size(), 32'd5);
        for (int i = 1; i < t_rr.size(); i++) begin
            check($sformatf("rr gap %0d", i), t_rr[i] - t_rr[i-1], 32'd3);
        end

        // Reset while a ch0 word sits in EMIT; sel must return to CHANNELS-1.
        rr_zack = 1'b0;
        rr_data = {48'h0, 16'h00A0};
        rr_stb  = 4'b0001;
        wait_sig(0);
        check("rr emit word", {rr_tag, rr_z}, {14'h0, 2'd0, 16'h00A0});
        rst    = 1'b1;
        rr_stb = '0;
        tick();
        check("rr after reset", {rr_zstb, rr_ack, rr_tag, rr_z}, 32'h0);
        rst = 1'b0;
        rr_data = {32'h0, 16'h00B1, 16'h00B0};
        q_rr.push_back({2'd0, 16'h00B0});
        q_rr.push_back({2'd1, 16'h00B1});
        rr_zack = 1'b1;
        rr_stb  = 4'b0011;
        wait_words(0, n_rr + 2);
        rr_stb = '0;

        // Backpressure: ch3 word held in EMIT for 10 cycles.
        rr_zack = 1'b0;
        rr_data = {16'h3333, 48'h0};
        rr_stb  = 4'b1000;
        wait_sig(0);
        rr_stb = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp hold %0d", i), {rr_zstb, rr_ack, rr_tag, rr_z},
                  {9'h0, 1'b1, 4'b0000, 2'd3, 16'h3333});
        end
        q_rr.push_back({2'd3, 16'h3333});
        rr_zack = 1'b1;
        wait_words(0, n_rr + 1);
        repeat (6) tick();

        // Fixed priority: ch1 starves ch3 until it drops.
        fx_data = {16'h0033, 16'h0, 16'h0011, 16'h0};
        repeat (3) q_fx.push_back({2'd1, 16'h0011});
        fx_stb = 4'b1010;
        wait_words(1, 3);
        fx_stb = 4'b1000;
        q_fx.push_back({2'd3, 16'h0033});
        wait_words(1, 4);
        fx_stb = '0;

        // Burst lock of 3 between ch0 and ch2.
        bu_data = {16'h0, 16'h00C2, 16'h0, 16'h00C0};
        repeat (3) q_bu.push_back({2'd0, 16'h00C0});
        repeat (3) q_bu.push_back({2'd2, 16'h00C2});
        q_bu.push_back({2'd0, 16'h00C0});
        bu_stb = 4'b0101;
        wait_words(2, 7);
        bu_stb = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        // ch0 leaves after two words of its burst; the lock must release to ch2.
        repeat (2) q_bu.push_back({2'd0, 16'h00C0});
        bu_stb = 4'b0101;
        wait_words(2, 9);
        bu_stb = 4'b0100;
        repeat (3) q_bu.push_back({2'd2, 16'h00C2});
        wait_words(2, 12);
        bu_stb = '0;

        // Three-channel wrap: grant ch2, then ch1 alone must be found past the wrap.
        w3_data = {16'h0052, 16'h0051, 16'h0050};
        q_w3.push_back({2'd2, 16'h0052});
        w3_stb = 3'b100;
        wait_words(3, 1);
        w3_stb = '0;
        tick();
        q_w3.push_back({2'd1, 16'h0051});
        w3_stb = 3'b010;
        wait_sig(3);
        check("w3 ack", 32'(w3_ack), 32'b010);
        wait_words(3, 2);
        w3_stb = '0;

        repeat (6) tick();
        check("rr queue empty", q_rr.size(), 32'd0);
        check("fx queue empty", q_fx.size(), 32'd0);
        check("bu queue empty", q_bu.size(), 32'd0);
        check("w3 queue empty", q_w3.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
